// File: rtl/morph_filter_3x3.sv
// 3x3 binary morphology (dilate / erode / bypass, square or cross kernel) with internal line buffers.
// Define MORPH_STAT_EN to add the per-frame foreground pixel counter on fg_count.
module morph_filter_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 16,
    parameter int BIT_SEL    = 0,
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int CNT_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              shape,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_clken,
    input  logic [DATA_W-1:0] pre_img_Y,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y,
    output logic              post_img_bit,
    output logic [CNT_W-1:0]  fg_count
);

    localparam int LAT = 3;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {OP_BYP = 2'b00, OP_DIL = 2'b01, OP_ERO = 2'b10} op_e;
    typedef struct packed {logic vsync; logic hsync; logic clken;} sb_t;

    logic             vs_prev_q, hs_prev_q, armed_q, armed_d;
    logic             vs_rise, hs_fall, pix_en, lb_we, pix_bit;
    op_e              mode_op, op_q, op_d;
    logic             shape_q, shape_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_full_q, col_full_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             lb0_q [IMG_WIDTH];
    logic             lb1_q [IMG_WIDTH];
    logic             lb0_rd, lb1_rd;

    // Window is [row][col]: row 0 = r-2, col 0 = c-2. ok masks mark taps inside the image.
    logic [2:0][2:0]  win_q, win_d;
    logic [2:0]       rok_q, rok_d, cok_q, cok_d;
    op_e              s0_op_q, s0_op_d;
    logic             s0_shape_q, s0_shape_d;
    logic [2:0][2:0]  tap, kin;
    logic [2:0]       red_q, red_d;
    op_e              s1_op_q;
    logic             res;
    sb_t              sb_in;
    sb_t [LAT:1]      sb_pipe_q, sb_pipe_d;
    logic             bit_q, bit_d;
    logic [DATA_W-1:0] img_q, img_d;

    logic unused_pix;
    assign unused_pix = ^pre_img_Y;

    always_comb begin
        vs_rise = pre_frame_vsync & ~vs_prev_q;
        hs_fall = hs_prev_q & ~pre_frame_hsync;
        armed_d = armed_q | vs_rise;
        pix_en  = pre_frame_clken & armed_d;
        pix_bit = pre_img_Y[BIT_SEL];
        lb_we   = pix_en & ~col_full_q;
        lb0_rd  = lb0_q[col_q];
        lb1_rd  = lb1_q[col_q];

        case (mode)
            2'b01:   mode_op = OP_DIL;
            2'b10:   mode_op = OP_ERO;
            default: mode_op = OP_BYP;
        endcase
        op_d    = vs_rise ? mode_op : op_q;
        shape_d = vs_rise ? shape : shape_q;

        col_d      = col_q;
        col_full_d = col_full_q;
        if (vs_rise || hs_fall) begin
            col_d      = '0;
            col_full_d = 1'b0;
        end else if (pix_en) begin
            if (col_q == COL_MAX) col_full_d = 1'b1;
            else                  col_d      = col_q + 1'b1;
        end

        row_d = row_q;
        if (vs_rise)                        row_d = '0;
        else if (hs_fall && row_q != ROW_MAX) row_d = row_q + 1'b1;

        win_d      = win_q;
        rok_d      = rok_q;
        cok_d      = cok_q;
        s0_op_d    = s0_op_q;
        s0_shape_d = s0_shape_q;
        if (pix_en) begin
            win_d[0]   = {lb1_rd,  win_q[0][2:1]};
            win_d[1]   = {lb0_rd,  win_q[1][2:1]};
            win_d[2]   = {pix_bit, win_q[2][2:1]};
            rok_d      = {1'b1, row_q != '0, row_q > ROW_W'(1)};
            cok_d      = {1'b1, col_q != '0, col_q > COL_W'(1)};
            s0_op_d    = op_d;
            s0_shape_d = shape_d;
        end
    end

    // Out-of-image taps take the neutral value of the operation, so borders never bleed.
    always_comb begin
        tap   = '0;
        kin   = '0;
        red_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tap[i][j] = (rok_q[i] & cok_q[j]) ? win_q[i][j] : (s0_op_q == OP_ERO);
                kin[i][j] = ~s0_shape_q | (i == 1) | (j == 1);
            end
            case (s0_op_q)
                OP_DIL:  red_d[i] = |(tap[i] & kin[i]);
                OP_ERO:  red_d[i] = &(tap[i] | ~kin[i]);
                default: red_d[i] = (i == 1) ? tap[1][1] : 1'b0;
            endcase
        end
    end

    always_comb begin
        case (s1_op_q)
            OP_DIL:  res = |red_q;
            OP_ERO:  res = &red_q;
            default: res = red_q[1];
        endcase
        bit_d     = res;
        img_d     = sb_pipe_q[LAT-1].hsync ? {DATA_W{res}} : '0;
        sb_in     = armed_d ? {pre_frame_vsync, pre_frame_hsync, pre_frame_clken} : 3'b000;
        sb_pipe_d = {sb_pipe_q[LAT-1:1], sb_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Track live sync levels through reset so a mid-frame reset is not mistaken for a frame start.
            vs_prev_q  <= pre_frame_vsync;
            hs_prev_q  <= pre_frame_hsync;
            armed_q    <= 1'b0;
            op_q       <= OP_BYP;
            shape_q    <= 1'b0;
            col_q      <= '0;
            col_full_q <= 1'b0;
            row_q      <= '0;
            win_q      <= '0;
            rok_q      <= '0;
            cok_q      <= '0;
            s0_op_q    <= OP_BYP;
            s0_shape_q <= 1'b0;
            red_q      <= '0;
            s1_op_q    <= OP_BYP;
            sb_pipe_q  <= '0;
            bit_q      <= 1'b0;
            img_q      <= '0;
        end else begin
            vs_prev_q  <= pre_frame_vsync;
            hs_prev_q  <= pre_frame_hsync;
            armed_q    <= armed_d;
            op_q       <= op_d;
            shape_q    <= shape_d;
            col_q      <= col_d;
            col_full_q <= col_full_d;
            row_q      <= row_d;
            win_q      <= win_d;
            rok_q      <= rok_d;
            cok_q      <= cok_d;
            s0_op_q    <= s0_op_d;
            s0_shape_q <= s0_shape_d;
            red_q      <= red_d;
            s1_op_q    <= s0_op_q;
            sb_pipe_q  <= sb_pipe_d;
            bit_q      <= bit_d;
            img_q      <= img_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb0_q[col_q] <= pix_bit;
            lb1_q[col_q] <= lb0_rd;
        end
    end

    assign post_frame_vsync = sb_pipe_q[LAT].vsync;
    assign post_frame_hsync = sb_pipe_q[LAT].hsync;
    assign post_frame_clken = sb_pipe_q[LAT].clken;
    assign post_img_bit     = bit_q;
    assign post_img_Y       = img_q;

`ifdef MORPH_STAT_EN
    logic             pvs_prev_q;
    logic [CNT_W-1:0] stat_q, stat_d, fg_q, fg_d;

    always_comb begin
        stat_d = stat_q;
        if (post_frame_vsync && !pvs_prev_q)          stat_d = '0;
        else if (post_frame_clken && post_img_bit)    stat_d = stat_q + 1'b1;
        fg_d = (pvs_prev_q && !post_frame_vsync) ? stat_q : fg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pvs_prev_q <= 1'b0;
            stat_q     <= '0;
            fg_q       <= '0;
        end else begin
            pvs_prev_q <= post_frame_vsync;
            stat_q     <= stat_d;
            fg_q       <= fg_d;
        end
    end

    assign fg_count = fg_q;
`else
    assign fg_count = '0;
`endif

endmodule

// File: tb/tb_morph_filter_3x3.sv
// Bench for morph_filter_3x3 on an 8x8 image: vector table, mode-latch and reset sequences, random frames.
`timescale 1ns/1ps
module tb_morph_filter_3x3;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DW   = 16;
    localparam int BSEL = 0;
    localparam int CW   = $clog2(W * H + 1);

    localparam int P_ZERO  = 0;
    localparam int P_ONES  = 1;
    localparam int P_DOT   = 2;
    localparam int P_BLOCK = 3;
    localparam int P_RAND  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          shape;
    logic          vsync, hsync, clken;
    logic [DW-1:0] pix;
    logic          post_vsync, post_hsync, post_clken, post_bit;
    logic [DW-1:0] post_y;
    logic [CW-1:0] fg_count;

    always #5 clk = ~clk;

    morph_filter_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW), .BIT_SEL(BSEL)) dut (
        .clk(clk), .rst(rst), .mode(mode), .shape(shape),
        .pre_frame_vsync(vsync), .pre_frame_hsync(hsync), .pre_frame_clken(clken),
        .pre_img_Y(pix),
        .post_frame_vsync(post_vsync), .post_frame_hsync(post_hsync),
        .post_frame_clken(post_clken), .post_img_Y(post_y), .post_img_bit(post_bit),
        .fg_count(fg_count)
    );

    typedef struct { int r; int c; logic b; } exp_t;
    typedef struct { int pat; logic [1:0] mode; logic shape; int exp_ones; } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t expq[$];
    logic img [H][W];
    int   dut_ones;
    int   model_ones;
    bit   pix_chk;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    // Result for input pixel (r,c) is the morphology of the neighbourhood around (r-1,c-1).
    function automatic logic ref_px(int r, int c, logic [1:0] m, logic s);
        int   cr = r - 1;
        int   cc = c - 1;
        logic pad, acc, v;
        if (m == 2'b01 || m == 2'b10) begin
            pad = (m == 2'b10);
            acc = pad;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (!(s && dr != 0 && dc != 0)) begin
                        v   = (cr + dr < 0 || cc + dc < 0) ? pad : img[cr + dr][cc + dc];
                        acc = (m == 2'b01) ? (acc | v) : (acc & v);
                    end
                end
            end
            return acc;
        end
        return (cr < 0 || cc < 0) ? 1'b0 : img[cr][cc];
    endfunction

    task automatic load_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    P_ONES:  img[r][c] = 1'b1;
                    P_DOT:   img[r][c] = (r == 3 && c == 3);
                    P_BLOCK: img[r][c] = (r >= 2 && r <= 5 && c >= 2 && c <= 5);
                    P_RAND:  img[r][c] = ($urandom_range(0, 99) < 40);
                    default: img[r][c] = 1'b0;
                endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [1:0] m, input logic s, input logic [1:0] m_mid,
                         input int mid_row, input int rst_row);
        logic b;
        mode       = m;
        shape      = s;
        pix_chk    = 1'b1;
        dut_ones   = 0;
        model_ones = 0;
        vsync      = 1'b1;
        step(); step();
        for (int r = 0; r < H; r++) begin
            if (r == mid_row) mode = m_mid;
            if (r == rst_row) begin
                rst = 1'b1;
                step();
                chk("post_rst_sidebands", 32'({post_vsync, post_hsync, post_clken, post_bit}), 32'd0);
                chk("post_rst_img_y", 32'(post_y), 32'd0);
                chk("post_rst_fg_count", 32'(fg_count), 32'd0);
                rst = 1'b0;
                expq.delete();
                pix_chk = 1'b0;
            end
            hsync = 1'b1;
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(0, 99) < 30) begin
                    clken = 1'b0;
                    pix   = DW'($urandom);
                    step();
                end
                clken     = 1'b1;
                pix       = DW'($urandom);
                pix[BSEL] = img[r][c];
                if (pix_chk) begin
                    b = ref_px(r, c, m, s);
                    expq.push_back('{r, c, b});
                    model_ones += int'(b);
                end
                step();
            end
            clken = 1'b0;
            hsync = 1'b0;
            repeat (3) step();
        end
        vsync = 1'b0;
        repeat (8) step();
    endtask

    task automatic end_check(input int want);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("frame_ones", 32'(dut_ones), 32'(want));
`ifdef MORPH_STAT_EN
        chk("fg_count", 32'(fg_count), 32'(want));
`else
        chk("fg_count_tied", 32'(fg_count), 32'd0);
`endif
    endtask

    // Expected sidebands: inputs delayed three cycles, held low until a frame start after reset.
    logic [2:0] sbh [3];
    logic       armed_m, vprev_m;
    always @(posedge clk) begin
        if (rst) begin
            armed_m <= 1'b0;
            vprev_m <= vsync;
            sbh[0]  <= 3'b0;
            sbh[1]  <= 3'b0;
            sbh[2]  <= 3'b0;
        end else begin
            vprev_m <= vsync;
            if (vsync && !vprev_m) armed_m <= 1'b1;
            sbh[0] <= (armed_m || (vsync && !vprev_m)) ? {vsync, hsync, clken} : 3'b0;
            sbh[1] <= sbh[0];
            sbh[2] <= sbh[1];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("sidebands", 32'({post_vsync, post_hsync, post_clken}), 32'(sbh[2]));
            if (!post_hsync) chk("img_y_blank", 32'(post_y), 32'd0);
            if (post_clken) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got bit %0b expected no pixel", post_bit);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("bit(%0d,%0d)", e.r, e.c), 32'(post_bit), 32'(e.b));
                    chk($sformatf("img_y(%0d,%0d)", e.r, e.c), 32'(post_y), 32'({DW{e.b}}));
                    dut_ones += int'(post_bit);
                end
            end
        end
    end

    vec_t vt [8];

    initial begin
        vt[0] = '{P_DOT,   2'b01, 1'b0, 9};
        vt[1] = '{P_DOT,   2'b01, 1'b1, 5};
        vt[2] = '{P_ONES,  2'b10, 1'b0, 64};
        vt[3] = '{P_ONES,  2'b01, 1'b0, 64};
        vt[4] = '{P_ZERO,  2'b01, 1'b0, 0};
        vt[5] = '{P_BLOCK, 2'b10, 1'b0, 4};
        vt[6] = '{P_DOT,   2'b00, 1'b0, 1};
        vt[7] = '{P_DOT,   2'b11, 1'b1, 1};

        rst = 1'b1; mode = 2'b00; shape = 1'b0;
        vsync = 1'b0; hsync = 1'b0; clken = 1'b0; pix = '0;
        repeat (3) step();
        chk("reset_outputs", 32'({post_vsync, post_hsync, post_clken, post_bit}), 32'd0);
        chk("reset_img_y", 32'(post_y), 32'd0);
        chk("reset_fg_count", 32'(fg_count), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) step();

        for (int k = 0; k < 8; k++) begin
            load_img(vt[k].pat);
            frame(vt[k].mode, vt[k].shape, vt[k].mode, -1, -1);
            end_check(vt[k].exp_ones);
        end

        // Mode change mid-frame must not take effect until the next frame.
        load_img(P_BLOCK);
        frame(2'b01, 1'b0, 2'b10, 3, -1);
        end_check(36);
        frame(2'b10, 1'b0, 2'b10, -1, -1);
        end_check(4);

        // Reset pulse at line 3, then a full frame must be processed correctly.
        load_img(P_RAND);
        frame(2'b01, 1'b0, 2'b01, -1, 3);
        chk("rst_frame_queue", 32'(expq.size()), 32'd0);
        chk("rst_frame_fg_count", 32'(fg_count), 32'd0);
        load_img(P_RAND);
        frame(2'b10, 1'b1, 2'b10, -1, -1);
        end_check(model_ones);

        for (int k = 0; k < 4; k++) begin
            load_img(P_RAND);
            frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'b00, -1, -1);
            end_check(model_ones);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morph_filter_3x3.md
Name: morph_filter_3x3

Overview:
- Parametrised successor to the fixed 3x3 binary dilation stage in the gesture-recognition video pipeline.
- Contains its own line buffers, so no external matrix generator is needed.
- Runtime-selectable operation: dilate, erode or bypass. Runtime-selectable kernel shape: square or cross.
- Border pixels are padded so edges do not bleed; sits between the Sobel/binarisation stage and the gesture feature extractor.

Parameters:
- IMG_WIDTH, 640: active pixels per line; sets line-buffer depth and column-counter range.
- IMG_HEIGHT, 480: active lines per frame; sets row-counter range.
- DATA_W, 16: width of the pixel bus in and out.
- BIT_SEL, 0: index of the pre_img_Y bit used as the binary input pixel.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- mode  in  2  00 bypass, 01 dilate, 10 erode, 11 reserved (treated as bypass); sampled at vsync rising edge
- shape  in  1  0 = 3x3 square, 1 = cross (centre plus 4-neighbours); sampled at vsync rising edge
- pre_frame_vsync  in  1  frame valid, high for the whole frame
- pre_frame_hsync  in  1  line valid
- pre_frame_clken  in  1  pixel valid
- pre_img_Y  in  DATA_W  input pixel; only bit BIT_SEL is used
- post_frame_vsync  out  1  vsync delayed by LAT
- post_frame_hsync  out  1  hsync delayed by LAT
- post_frame_clken  out  1  clken delayed by LAT
- post_img_Y  out  DATA_W  result bit replicated to DATA_W when post_frame_hsync = 1, else 0
- post_img_bit  out  1  raw result bit
- fg_count  out  clog2(IMG_WIDTH*IMG_HEIGHT+1)  foreground count of the last frame (optional feature)

Behaviour:
- Reset: all outputs 0; line buffers need not be cleared; counters 0; latched mode = 00, latched shape = 0.
- LAT = 3 cycles, fixed:
  - S0: line-buffer read and window shift.
  - S1: per-row reduction.
  - S2: final reduction.
  - Output registers follow S2. The vsync, hsync and clken sidebands travel through a matching 3-deep shift register.
- Window update: only on clken-qualified cycles.
  - The window holds rows r-2, r-1, r and columns c-2..c.
  - Output for input pixel (r,c) is the morphology of the window centred at (r-1, c-1). This one-row, one-column offset is intended; downstream compensates.
- Line buffers: two buffers, IMG_WIDTH deep, 1 bit wide, indexed by the column counter. Read and write happen in the same cycle with read-before-write.
- Column counter: increments on clken; clears on the hsync falling edge; saturates at IMG_WIDTH-1 if a line is over-long. Extra pixels are processed, but the line buffers are not written.
- Row counter: increments on the hsync falling edge; clears on the vsync rising edge.
- Padding, for window taps outside the image (row < 0 or column < 0 of the centre neighbourhood, i.e. rows 0-1 and columns 0-1 of the counter):
  - Dilate: padded value 0.
  - Erode: padded value 1.
  - Padding is applied by masking taps whose row/column index is invalid, not by clearing the buffers.
- Operations:
  - Dilate: OR over the kernel taps.
  - Erode: AND over the kernel taps.
  - Square uses 9 taps; cross uses p12, p21, p22, p23, p32.
  - Bypass: result = centre tap p22, with the same LAT and offset.
- mode and shape changes mid-frame are ignored until the next vsync rising edge, so no frame uses mixed operations.
- rst asserted mid-frame: pipeline and sidebands clear on the next edge; processing resumes at the next vsync rising edge. Any partial frame after reset is undefined but must keep sidebands low until a vsync rising edge is seen.
- clken low cycles: window and counters hold; sidebands still shift every cycle, so a clken gap propagates unchanged.

Optional Feature:
- Macro: MORPH_STAT_EN.
- Defined: a counter increments on each post_frame_clken with post_img_bit = 1; it clears on the post_frame_vsync rising edge. Its value is latched into fg_count on the post_frame_vsync falling edge. Reset value 0.
- Undefined: fg_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=8, dilate, square; single 1 at (3,3), all else 0 -> output 1 exactly at positions (3..5, 3..5) (offset window), 9 ones in total; fg_count=9 with MORPH_STAT_EN.
- Same image, dilate, cross -> 5 ones at (4,4), (3,4), (5,4), (4,3), (4,5).
- All-ones frame, erode, square -> all outputs 1, including the row-0/1 and column-0/1 borders (pad=1); all-ones frame, dilate -> all 1; all-zeros frame, dilate -> all 0.
- 4x4 block of ones at rows/columns 2..5, erode, square -> 2x2 ones at output positions (4..5, 4..5).
- mode toggled dilate->erode mid-frame -> current frame is entirely dilated; the next frame is eroded.
- Random clken gaps (about 30% low) plus rst pulsed for 1 cycle at line 3 -> sidebands equal the inputs delayed by exactly 3 cycles; all outputs are 0 the cycle after rst; processing resumes correctly from the next frame.
